seq_divider32: RTL
==================

SEQ_DIVIDER32 -- requirements
Module: seq_divider32

Interface
REQ-001 The block SHALL have one parameter: N, default 16, operand width (divisor, quotient and remainder are N bits; dividend is 2N bits).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 The block SHALL provide these ports, clock and reset first:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  2N  unsigned dividend; captured when start is accepted
- divisor  input  N  unsigned divisor; captured when start is accepted
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  divisor was 0
- overflow  output  1  quotient does not fit in N bits

Function
REQ-004 The block SHALL be the inverse of the team's 16x16->32 product path: it SHALL compute the unsigned quotient and remainder of a 2N-bit dividend divided by an N-bit divisor, with dividend = quotient*divisor + remainder and remainder < divisor.
REQ-005 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-006 IDLE SHALL go to CALC on a clock edge with start=1. On that edge the block SHALL capture the operands, set busy=1, and clear div_by_zero and overflow.
REQ-007 In IDLE with start=1 and divisor=0, the block SHALL go to DONE instead of CALC, with div_by_zero=1, quotient=all ones and remainder=dividend[N-1:0].
REQ-008 In IDLE with start=1, divisor!=0 and dividend[2N-1:N] >= divisor, the block SHALL go to DONE instead of CALC, with overflow=1, quotient=all ones and remainder=dividend[N-1:0].
REQ-009 CALC SHALL use a restoring shift-subtract:
- partial remainder: N+1 bits, initialised to dividend[2N-1:N]
- each cycle: shift in one dividend bit, MSB of the low half first
- if the shifted value >= divisor: subtract divisor and shift 1 into the quotient; otherwise shift 0
- exactly N CALC cycles, counted by an iteration counter
REQ-010 After the Nth CALC cycle the block SHALL go to DONE; on that edge quotient and remainder SHALL update and busy SHALL fall.
REQ-011 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-012 A normal operation SHALL assert done in the cycle beginning N+1 edges after the start-accepting edge (17 edges for N=16); an exception operation SHALL assert done after 1 edge.
REQ-013 The block SHALL ignore start while busy=1 or done=1; the captured operands SHALL be unaffected.
REQ-014 start held high across DONE SHALL be accepted on the first IDLE cycle after DONE, giving back-to-back operations with one idle cycle between them.
REQ-015 quotient, remainder, div_by_zero and overflow SHALL hold their values from done until the next accepted start.
REQ-016 Operand inputs SHALL be don't-care except on the start-accepting edge.

Reset
REQ-017 On a clock edge with rst=1, the block SHALL enter IDLE and clear busy, done, quotient, remainder, div_by_zero, overflow and the iteration counter to 0.
REQ-018 rst SHALL take priority over start.
REQ-019 rst asserted mid-CALC SHALL abort the operation with no done pulse.
REQ-020 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios (N=16):
- dividend=100, divisor=7, one-cycle start -> quotient=14, remainder=2, done 17 edges after start, busy high for 16 cycles
- dividend=0xFFFE_FFFF, divisor=0xFFFF -> quotient=0xFFFF, remainder=0xFFFE, overflow=0 (exercises the N+1-bit partial-remainder carry)
- dividend=0x1234_5678, divisor=0 -> div_by_zero=1, quotient=0xFFFF, remainder=0x5678, done 1 edge after start
- dividend=0x0001_0000, divisor=1 -> overflow=1, quotient=0xFFFF, remainder=0x0000, done 1 edge after start
- start 100/7, then start 50/5 pulsed mid-CALC, then rst at the 8th CALC cycle -> second start ignored, no done, all outputs 0; then 50/5 -> quotient=10, remainder=0
- start held high for 40 cycles with 1000/10 -> two done pulses, 18 edges apart, each with quotient=100, remainder=0

Source files
------------

// File: rtl/seq_divider32.sv
// Sequential unsigned divider: 2N-bit dividend / N-bit divisor -> N-bit quotient and remainder.
// Restoring shift-subtract, one quotient bit per cycle; zero divisor and quotient overflow finish in one cycle.
module seq_divider32 #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(N) + 1;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [N-1:0]  rem_reg;
    logic [N-1:0]  dq_reg;
    logic [N-1:0]  dvsr_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [N-1:0]  quotient_reg;
    logic [N-1:0]  remainder_reg;
    logic          dbz_reg;
    logic          ovf_reg;

    // The N+1-bit partial remainder is the shifted value; the stored remainder always fits in N bits.
    logic [N:0]    shifted_next;
    logic          ge_next;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  dq_next;

    always_comb begin
        shifted_next = {rem_reg, dq_reg[N-1]};
        ge_next      = (shifted_next >= {1'b0, dvsr_reg});
        // When subtracting, the result is below the divisor, so modulo-2^N arithmetic is exact.
        rem_next     = ge_next ? (shifted_next[N-1:0] - dvsr_reg) : shifted_next[N-1:0];
        dq_next      = {dq_reg[N-2:0], ge_next};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dq_reg        <= '0;
            dvsr_reg      <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        dbz_reg <= 1'b0;
                        ovf_reg <= 1'b0;
                        if (divisor == '0) begin
                            dbz_reg       <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= dividend[N-1:0];
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else if (dividend[2*N-1:N] >= divisor) begin
                            ovf_reg       <= 1'b1;
                            quotient_reg  <= '1;
                            remainder_reg <= dividend[N-1:0];
                            done_reg      <= 1'b1;
                            state_reg     <= DONE;
                        end else begin
                            rem_reg   <= dividend[2*N-1:N];
                            dq_reg    <= dividend[N-1:0];
                            dvsr_reg  <= divisor;
                            cnt_reg   <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    dq_reg  <= dq_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(N - 1)) begin
                        quotient_reg  <= dq_next;
                        remainder_reg <= rem_next;
                        busy_reg      <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;
    assign overflow    = ovf_reg;

endmodule
